multicycle_ctrl: RTL and testbench

- Multi-cycle sequencer for the RV32I core.
- Takes the one-hot instruction-class vector from the decoder and steps the shared datapath through FETCH, DECODE, EXEC, MEM and WB.
- Sequences the instruction- and data-memory handshakes, guards both with a timeout, counts retired instructions, and traps on illegal class vectors or bus timeouts.
- Sits between the decoder/ALU-control logic and the PC, IR, register file and memory ports.

---
 rtl/rv32_ctrl_pkg.sv | 35 +++
 rtl/class_decode.sv | 40 ++++
 rtl/multicycle_ctrl.sv | 154 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle control path: FSM states, decoder class
// bit positions and the PC / write-back mux select codes.
package rv32_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StTrap   = 3'd6
  } state_e;

  // Bit positions within the one-hot instruction-class vector
  localparam int unsigned DecLui    = 0;
  localparam int unsigned DecAuipc  = 1;
  localparam int unsigned DecJalr   = 2;
  localparam int unsigned DecJal    = 3;
  localparam int unsigned DecBranch = 4;
  localparam int unsigned DecStore  = 5;
  localparam int unsigned DecLoad   = 6;
  localparam int unsigned DecIAlu   = 7;
  localparam int unsigned DecRType  = 8;

  localparam logic [1:0] PcPlus4 = 2'd0;
  localparam logic [1:0] PcImm   = 2'd1;
  localparam logic [1:0] PcAlu   = 2'd2;

  localparam logic [1:0] WbAlu  = 2'd0;
  localparam logic [1:0] WbLoad = 2'd1;
  localparam logic [1:0] WbPc4  = 2'd2;
  localparam logic [1:0] WbImm  = 2'd3;

endpackage

// File: rtl/class_decode.sv
// Combinational one-hot legality check and class-to-select mapping for the sequencer.
module class_decode
  import rv32_ctrl_pkg::*;
(
  input  logic [8:0] dec,
  output logic       legal,
  output logic       is_branch,
  output logic       is_load,
  output logic       is_store,
  output logic [1:0] wb_sel,
  output logic [1:0] pc_sel
);

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing
  assign legal     = (dec != '0) && ((dec & (dec - 9'd1)) == '0);
  assign is_branch = dec[DecBranch];
  assign is_load   = dec[DecLoad];
  assign is_store  = dec[DecStore];

  always_comb begin
    wb_sel = WbAlu;
    pc_sel = PcPlus4;
    if (dec[DecLoad]) begin
      wb_sel = WbLoad;
    end else if (dec[DecJal]) begin
      wb_sel = WbPc4;
      pc_sel = PcImm;
    end else if (dec[DecJalr]) begin
      wb_sel = WbPc4;
      pc_sel = PcAlu;
    end else if (dec[DecLui]) begin
      wb_sel = WbImm;
    end else if (dec[DecAuipc] || dec[DecIAlu] || dec[DecRType]) begin
      // AUIPC has the ALU form pc+imm, so it writes back like an ALU op
      wb_sel = WbAlu;
      pc_sel = PcPlus4;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB FSM with bus timeouts,
// retired-instruction counter and sticky trap on illegal class or timeout.
module multicycle_ctrl
  import rv32_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [8:0]  dec,
  input  logic        br_taken,
  input  logic        imem_ack,
  input  logic        dmem_ack,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        ir_we,
  output logic        rf_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic [1:0]  wb_sel,
  output logic [31:0] instret,
  output logic        trap,
  output logic        bus_err,
  output logic [2:0]  state
);

  localparam logic [7:0] Limit = 8'(TIMEOUT);

  state_e      state_q, state_d;
  logic [8:0]  cls_q, cls_in;
  logic [7:0]  wait_q, wait_d, wait_inc;
  logic [31:0] instret_q;
  logic        trap_q, trap_d, bus_err_q, bus_err_d;
  logic        legal, is_branch, is_load, is_store;
  logic [1:0]  cd_wb_sel, cd_pc_sel;
  logic        waiting, ack, wait_hit;

  // The class is sampled from the decoder only in DECODE and held afterwards
  assign cls_in = (state_q == StDecode) ? dec : cls_q;

  class_decode u_class_decode (
    .dec       (cls_in),
    .legal     (legal),
    .is_branch (is_branch),
    .is_load   (is_load),
    .is_store  (is_store),
    .wb_sel    (cd_wb_sel),
    .pc_sel    (cd_pc_sel)
  );

  assign waiting  = (state_q == StFetch) || (state_q == StMem);
  assign ack      = ((state_q == StFetch) && imem_ack) || ((state_q == StMem) && dmem_ack);
  assign wait_inc = wait_q + 8'd1;
  // An ack in the limit cycle still completes the access
  assign wait_hit = waiting && !ack && (wait_inc == Limit);

  always_comb begin
    state_d   = state_q;
    trap_d    = trap_q;
    bus_err_d = bus_err_q;
    unique case (state_q)
      StIdle:   if (en) state_d = StFetch;
      StFetch: begin
        if (imem_ack) begin
          state_d = StDecode;
        end else if (wait_hit) begin
          state_d   = StTrap;
          trap_d    = 1'b1;
          bus_err_d = 1'b1;
        end
      end
      StDecode: begin
        if (legal) begin
          state_d = StExec;
        end else begin
          state_d   = StTrap;
          trap_d    = 1'b1;
          bus_err_d = 1'b0;
        end
      end
      StExec: begin
        if (is_branch)                state_d = StFetch;
        else if (is_load || is_store) state_d = StMem;
        else                          state_d = StWb;
      end
      StMem: begin
        if (dmem_ack) begin
          state_d = is_load ? StWb : StFetch;
        end else if (wait_hit) begin
          state_d   = StTrap;
          trap_d    = 1'b1;
          bus_err_d = 1'b1;
        end
      end
      StWb:     state_d = StFetch;
      StTrap:   state_d = StTrap;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q) begin
      wait_d = '0;
    end else if (waiting && !ack) begin
      wait_d = wait_inc;
    end
  end

  always_comb begin
    imem_req = (state_q == StFetch);
    ir_we    = (state_q == StFetch) && imem_ack;
    dmem_req = (state_q == StMem);
    dmem_we  = (state_q == StMem) && is_store;
    rf_we    = (state_q == StWb);
    pc_we    = ((state_q == StExec) && is_branch) ||
               ((state_q == StMem) && is_store && dmem_ack) ||
               (state_q == StWb);
    pc_sel   = PcPlus4;
    wb_sel   = WbAlu;
    if ((state_q == StExec) && is_branch && br_taken) begin
      pc_sel = PcImm;
    end else if (state_q == StWb) begin
      pc_sel = cd_pc_sel;
      wb_sel = cd_wb_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      cls_q     <= '0;
      wait_q    <= '0;
      instret_q <= '0;
      trap_q    <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_in;
      wait_q    <= wait_d;
      trap_q    <= trap_d;
      bus_err_q <= bus_err_d;
      if (pc_we) instret_q <= instret_q + 32'd1;
    end
  end

  assign instret = instret_q;
  assign trap    = trap_q;
  assign bus_err = bus_err_q;
  assign state   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle strobe vectors with hand-derived expectations.
module tb_multicycle_ctrl;

  localparam logic [2:0] SI = 3'd0, SF = 3'd1, SD = 3'd2, SE = 3'd3;
  localparam logic [2:0] SM = 3'd4, SW = 3'd5, ST = 3'd6;

  localparam logic [8:0] LUI = 9'h001, AUIPC = 9'h002, JALR = 9'h004, JAL = 9'h008;
  localparam logic [8:0] BR = 9'h010, STO = 9'h020, LD = 9'h040, IALU = 9'h080, RT = 9'h100;

  logic        clk = 1'b0;
  logic        rst, en, br_taken, imem_ack, dmem_ack;
  logic [8:0]  dec;
  logic        imem_req, dmem_req, dmem_we, ir_we, rf_we, pc_we, trap, bus_err;
  logic [1:0]  pc_sel, wb_sel;
  logic [31:0] instret;
  logic [2:0]  state;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        ia;
    logic        da;
    logic [8:0]  d;
    logic        tk;
    logic [12:0] ex;
  } vec_t;

  multicycle_ctrl #(.TIMEOUT(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .dec      (dec),
    .br_taken (br_taken),
    .imem_ack (imem_ack),
    .dmem_ack (dmem_ack),
    .imem_req (imem_req),
    .dmem_req (dmem_req),
    .dmem_we  (dmem_we),
    .ir_we    (ir_we),
    .rf_we    (rf_we),
    .pc_we    (pc_we),
    .pc_sel   (pc_sel),
    .wb_sel   (wb_sel),
    .instret  (instret),
    .trap     (trap),
    .bus_err  (bus_err),
    .state    (state)
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] mk(input logic [2:0] st, input logic ireq, input logic dreq,
                                     input logic dwe, input logic irwe, input logic rfwe,
                                     input logic pcwe, input logic [1:0] ps, input logic [1:0] ws);
    return {st, ireq, dreq, dwe, irwe, rfwe, pcwe, ps, ws};
  endfunction

  function automatic logic [12:0] snap();
    return {state, imem_req, dmem_req, dmem_we, ir_we, rf_we, pc_we, pc_sel, wb_sel};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ia, input logic da, input logic [8:0] d, input logic tk);
    imem_ack = ia;
    dmem_ack = da;
    dec      = d;
    br_taken = tk;
    #1;
  endtask

  // Runs an untimed branch from FETCH; used only to advance instret
  task automatic run_branch();
    drive(1, 0, 9'h000, 0); tick();
    drive(0, 0, BR, 0);     tick();
    drive(0, 0, 9'h000, 1); tick();
    drive(0, 0, 9'h000, 0);
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b1;
    drive(1, 1, RT, 1);
    tick(); tick();
    checks++;
    if ({state, trap, bus_err} !== {SI, 1'b0, 1'b0}) begin
      errors++; $display("FAIL reset_state: got %b want %b", {state, trap, bus_err}, {SI, 2'b00});
    end
    checks++;
    if (instret !== 32'd0) begin
      errors++; $display("FAIL reset_instret: got %h want 0", instret);
    end
    // imem_ack held high: only ir_we could be spuriously driven
    checks++;
    if (snap() !== mk(SI, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0)) begin
      errors++; $display("FAIL reset_strobes: got %b want %b", snap(), mk(SI,0,0,0,0,0,0,0,0));
    end
    en = 1'b0;
    rst = 1'b1;
    drive(0, 0, 9'h000, 0);
    tick(); tick();
    checks++;
    if (state !== SI) begin
      errors++; $display("FAIL idle_hold: got %0d want %0d", state, SI);
    end
  endtask

  task automatic test_rtype();
    vec_t v [4];
    v[0] = '{1'b1, 1'b0, 9'h000, 1'b0, mk(SF, 1, 0, 0, 1, 0, 0, 2'd0, 2'd0)};
    v[1] = '{1'b0, 1'b0, RT,     1'b0, mk(SD, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0)};
    v[2] = '{1'b0, 1'b0, 9'h1FF, 1'b0, mk(SE, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0)};
    v[3] = '{1'b0, 1'b0, 9'h000, 1'b0, mk(SW, 0, 0, 0, 0, 1, 1, 2'd0, 2'd0)};
    en = 1'b1;
    tick();
    en = 1'b0;
    for (int c = 0; c < 4; c++) begin
      drive(v[c].ia, v[c].da, v[c].d, v[c].tk);
      checks++;
      if (snap() !== v[c].ex) begin
        errors++; $display("FAIL rtype_c%0d: got %b want %b", c, snap(), v[c].ex);
      end
      if (c == 3) begin
        checks++;
        if (instret !== 32'd0) begin
          errors++; $display("FAIL rtype_instret_pre: got %h want 0", instret);
        end
      end
      tick();
    end
    checks++;
    if ({state, instret} !== {SF, 32'd1}) begin
      errors++; $display("FAIL rtype_post: got st=%0d ir=%h want st=1 ir=1", state, instret);
    end
  endtask

  task automatic test_load_late();
    vec_t v [8];
    v[0] = '{1'b1, 1'b0, 9'h000, 1'b0, mk(SF, 1, 0, 0, 1, 0, 0, 2'd0, 2'd0)};
    v[1] = '{1'b0, 1'b0, LD,     1'b0, mk(SD, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0)};
    v[2] = '{1'b0, 1'b1, 9'h000, 1'b0, mk(SE, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0)};
    v[3] = '{1'b0, 1'b0, 9'h000, 1'b0, mk(SM, 0, 1, 0, 0, 0, 0, 2'd0, 2'd0)};
    v[4] = '{1'b0, 1'b0, 9'h000, 1'b0, mk(SM, 0, 1, 0, 0, 0, 0, 2'd0, 2'd0)};
    v[5] = '{1'b0, 1'b0, 9'h000, 1'b0, mk(SM, 0, 1, 0, 0, 0, 0, 2'd0, 2'd0)};
    v[6] = '{1'b0, 1'b1, 9'h000, 1'b0, mk(SM, 0, 1, 0, 0, 0, 0, 2'd0, 2'd0)};
    v[7] = '{1'b0, 1'b0, 9'h000, 1'b0, mk(SW, 0, 0, 0, 0, 1, 1, 2'd0, 2'd1)};
    for (int c = 0; c < 8; c++) begin
      drive(v[c].ia, v[c].da, v[c].d, v[c].tk);
      checks++;
      if (snap() !== v[c].ex) begin
        errors++; $display("FAIL load_c%0d: got %b want %b", c, snap(), v[c].ex);
      end
      tick();
    end
    checks++;
    if ({state, instret} !== {SF, 32'd2}) begin
      errors++; $display("FAIL load_post: got st=%0d ir=%h want st=1 ir=2", state, instret);
    end
  endtask

  task automatic test_store();
    vec_t v [5];
    v[0] = '{1'b0, 1'b0, 9'h000, 1'b0, mk(SF, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0)};
    v[1] = '{1'b1, 1'b0, 9'h000, 1'b0, mk(SF, 1, 0, 0, 1, 0, 0, 2'd0, 2'd0)};
    v[2] = '{1'b0, 1'b0, STO,    1'b0, mk(SD, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0)};
    v[3] = '{1'b0, 1'b0, 9'h000, 1'b0, mk(SE, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0)};
    v[4] = '{1'b0, 1'b1, 9'h000, 1'b0, mk(SM, 0, 1, 1, 0, 0, 1, 2'd0, 2'd0)};
    for (int c = 0; c < 5; c++) begin
      drive(v[c].ia, v[c].da, v[c].d, v[c].tk);
      checks++;
      if (snap() !== v[c].ex) begin
        errors++; $display("FAIL store_c%0d: got %b want %b", c, snap(), v[c].ex);
      end
      tick();
    end
    checks++;
    if ({state, instret} !== {SF, 32'd3}) begin
      errors++; $display("FAIL store_post: got st=%0d ir=%h want st=1 ir=3", state, instret);
    end
  endtask

  task automatic test_branch();
    vec_t v [3];
    logic [31:0] exp_ir;
    for (int t = 1; t >= 0; t--) begin
      v[0] = '{1'b1, 1'b0, 9'h000, 1'b0, mk(SF, 1, 0, 0, 1, 0, 0, 2'd0, 2'd0)};
      v[1] = '{1'b0, 1'b0, BR,     1'b0, mk(SD, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0)};
      v[2] = '{1'b0, 1'b0, 9'h000, 1'(t), mk(SE, 0, 0, 0, 0, 0, 1, 2'(t), 2'd0)};
      for (int c = 0; c < 3; c++) begin
        drive(v[c].ia, v[c].da, v[c].d, v[c].tk);
        checks++;
        if (snap() !== v[c].ex) begin
          errors++; $display("FAIL branch_t%0d_c%0d: got %b want %b", t, c, snap(), v[c].ex);
        end
        tick();
      end
      exp_ir = (t == 1) ? 32'd4 : 32'd5;
      checks++;
      if ({state, instret} !== {SF, exp_ir}) begin
        errors++; $display("FAIL branch_t%0d_post: got st=%0d ir=%h want st=1 ir=%h",
                           t, state, instret, exp_ir);
      end
    end
  endtask

  task automatic test_wb_classes();
    logic [8:0] cls [5];
    logic [1:0] eps [5];
    logic [1:0] ews [5];
    logic [12:0] ex;
    cls[0] = JAL;   eps[0] = 2'd1; ews[0] = 2'd2;
    cls[1] = JALR;  eps[1] = 2'd2; ews[1] = 2'd2;
    cls[2] = LUI;   eps[2] = 2'd0; ews[2] = 2'd3;
    cls[3] = AUIPC; eps[3] = 2'd0; ews[3] = 2'd0;
    cls[4] = IALU;  eps[4] = 2'd0; ews[4] = 2'd0;
    for (int k = 0; k < 5; k++) begin
      drive(1, 0, 9'h000, 0); tick();
      drive(0, 0, cls[k], 0); tick();
      drive(0, 0, 9'h000, 1);
      checks++;
      if (snap() !== mk(SE, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0)) begin
        errors++; $display("FAIL wb_k%0d_exec: got %b want %b", k, snap(), mk(SE,0,0,0,0,0,0,0,0));
      end
      tick();
      drive(0, 0, 9'h000, 0);
      ex = mk(SW, 0, 0, 0, 0, 1, 1, eps[k], ews[k]);
      checks++;
      if (snap() !== ex) begin
        errors++; $display("FAIL wb_k%0d: got %b want %b", k, snap(), ex);
      end
      tick();
    end
    checks++;
    if ({state, instret} !== {SF, 32'd10}) begin
      errors++; $display("FAIL wb_post: got st=%0d ir=%h want st=1 ir=a", state, instret);
    end
  endtask

  task automatic test_reset_in_mem();
    drive(1, 0, 9'h000, 0); tick();
    drive(0, 0, STO, 0);    tick();
    drive(0, 0, 9'h000, 0); tick();
    drive(0, 0, 9'h000, 0);
    checks++;
    if (snap() !== mk(SM, 0, 1, 1, 0, 0, 0, 2'd0, 2'd0)) begin
      errors++; $display("FAIL rstmem_mem: got %b want %b", snap(), mk(SM,0,1,1,0,0,0,0,0));
    end
    // Reset and the data ack share the same edge: reset must win
    rst = 1'b0;
    drive(0, 1, 9'h000, 0);
    tick();
    drive(0, 0, 9'h000, 0);
    checks++;
    if ({state, instret} !== {SI, 32'd0}) begin
      errors++; $display("FAIL rstmem_post: got st=%0d ir=%h want st=0 ir=0", state, instret);
    end
    rst = 1'b1; en = 1'b1;
    tick();
    en = 1'b0;
  endtask

  task automatic test_wrap();
    logic [31:0] exp_ir [3];
    exp_ir[0] = 32'hFFFF_FFFF; exp_ir[1] = 32'h0000_0000; exp_ir[2] = 32'h0000_0001;
    force dut.instret_q = 32'hFFFF_FFFE;
    #1;
    release dut.instret_q;
    for (int k = 0; k < 3; k++) begin
      run_branch();
      checks++;
      if (instret !== exp_ir[k]) begin
        errors++; $display("FAIL wrap_%0d: got %h want %h", k, instret, exp_ir[k]);
      end
    end
  endtask

  task automatic test_illegal();
    int bad;
    drive(1, 0, 9'h000, 0); tick();
    drive(0, 0, 9'b000110000, 0);
    checks++;
    if (state !== SD) begin
      errors++; $display("FAIL illegal_decode: got %0d want %0d", state, SD);
    end
    tick();
    drive(0, 0, 9'h000, 0);
    checks++;
    if ({state, trap, bus_err} !== {ST, 1'b1, 1'b0}) begin
      errors++; $display("FAIL illegal_trap: got %b want %b", {state, trap, bus_err}, {ST, 2'b10});
    end
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      drive(1'($urandom_range(1)), 1'($urandom_range(1)), 9'($urandom), 1'($urandom_range(1)));
      if (snap() !== mk(ST, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0) || trap !== 1'b1 || instret !== 32'd1)
        bad++;
      tick();
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL illegal_hold: got %0d bad cycles want 0", bad);
    end
    rst = 1'b0;
    drive(0, 0, 9'h000, 0);
    tick();
    checks++;
    if ({state, trap, bus_err, instret} !== {SI, 1'b0, 1'b0, 32'd0}) begin
      errors++; $display("FAIL illegal_reset: got st=%0d trap=%b be=%b ir=%h want 0/0/0/0",
                         state, trap, bus_err, instret);
    end
    rst = 1'b1; en = 1'b1;
    tick();
    en = 1'b0;
  endtask

  task automatic test_timeout();
    run_branch();
    checks++;
    if (instret !== 32'd1) begin
      errors++; $display("FAIL timeout_pre: got %h want 1", instret);
    end
    for (int c = 0; c < 4; c++) begin
      drive(0, 0, 9'h000, 0);
      checks++;
      if (snap() !== mk(SF, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0)) begin
        errors++; $display("FAIL timeout_c%0d: got %b want %b", c, snap(), mk(SF,1,0,0,0,0,0,0,0));
      end
      tick();
    end
    checks++;
    if ({state, trap, bus_err, imem_req} !== {ST, 1'b1, 1'b1, 1'b0}) begin
      errors++; $display("FAIL timeout_trap: got %b want %b",
                         {state, trap, bus_err, imem_req}, {ST, 3'b110});
    end
    checks++;
    if (instret !== 32'd1) begin
      errors++; $display("FAIL timeout_instret: got %h want 1", instret);
    end
  endtask

  initial begin
    rst = 1'b0; en = 1'b0;
    drive(0, 0, 9'h000, 0);
    test_reset();
    test_rtype();
    test_load_late();
    test_store();
    test_branch();
    test_wb_classes();
    test_reset_in_mem();
    test_wrap();
    test_illegal();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
